alu_arbiter: RTL and testbench

- Shares one instance of the core's combinational alu between NREQ requesters (e.g. integer execute, address generation, branch compare).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin, one grant per cycle, and the result is registered in a single output slot.
- Sits between the issue logic and the shared alu inside the core.

---
 rtl/alu_arbiter_pkg.sv | 27 ++
 rtl/alu.sv | 31 +++
 rtl/alu_arbiter_rr.sv | 32 +++
 rtl/alu_arbiter.sv | 88 ++++++++
 tb/tb_alu_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// ALU select codes shared with the core's alu, plus the arbiter's request type.
// The codes are guarded so the core's define include can coexist with this file.
`ifndef ALU_DEFINES_SV
`define ALU_DEFINES_SV
`define ALU_NONE 4'h0
`define ALU_ADD  4'h1
`define ALU_SUB  4'h2
`define ALU_SLL  4'h3
`define ALU_SLT  4'h4
`define ALU_SLTU 4'h5
`define ALU_XOR  4'h6
`define ALU_SRL  4'h7
`define ALU_SRA  4'h8
`define ALU_OR   4'h9
`define ALU_AND  4'hA
`endif

package alu_arbiter_pkg;
  localparam int ALU_SEL_W = 4;
  localparam int ALU_DW    = 32;

  typedef struct packed {
    logic [ALU_SEL_W-1:0] sel;
    logic [ALU_DW-1:0]    op1;
    logic [ALU_DW-1:0]    op2;
  } alu_req_t;
endpackage

// File: rtl/alu.sv
// Shared combinational ALU; NONE and unknown select codes produce zero.
module alu #(
  parameter int DW = 32
) (
  input  logic [3:0]    sel,
  input  logic [DW-1:0] op1,
  input  logic [DW-1:0] op2,
  output logic [DW-1:0] res
);
  localparam int SHW = $clog2(DW);

  logic [SHW-1:0] shamt;
  assign shamt = op2[SHW-1:0];

  always_comb begin
    res = '0;
    case (sel)
      `ALU_ADD:  res = op1 + op2;
      `ALU_SUB:  res = op1 - op2;
      `ALU_SLL:  res = op1 << shamt;
      `ALU_SLT:  res = {{(DW-1){1'b0}}, ($signed(op1) < $signed(op2))};
      `ALU_SLTU: res = {{(DW-1){1'b0}}, (op1 < op2)};
      `ALU_XOR:  res = op1 ^ op2;
      `ALU_SRL:  res = op1 >> shamt;
      `ALU_SRA:  res = $unsigned($signed(op1) >>> shamt);
      `ALU_OR:   res = op1 | op2;
      `ALU_AND:  res = op1 & op2;
      default:   res = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter_rr.sv
// Round-robin arbiter: scans upward from ptr, wrapping modulo NREQ.
module alu_arbiter_rr #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  int             j;
  logic [IDW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      cand = IDW'(j);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) grant[idx] = 1'b1;
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu among NREQ requesters with round-robin grant and a single
// registered result slot that can drain and refill in the same cycle.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DW   = ALU_DW,
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*ALU_SEL_W-1:0] req_sel,
  input  logic [NREQ*DW-1:0]        req_op1,
  input  logic [NREQ*DW-1:0]        req_op2,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [DW-1:0]             rsp_res
);
  alu_req_t        reqs [NREQ];
  alu_req_t        win;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_idx;
  logic            win_any;
  logic [DW-1:0]   alu_res;

  logic            out_valid;
  logic [IDW-1:0]  out_id;
  logic [DW-1:0]   out_res;
  logic [IDW-1:0]  rr_ptr;

  logic            slot_drain;
  logic            slot_free;
  logic            grant_fire;

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign reqs[i] = '{sel: req_sel[ALU_SEL_W*i +: ALU_SEL_W],
                       op1: req_op1[DW*i +: DW],
                       op2: req_op2[DW*i +: DW]};
  end

  alu_arbiter_rr #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign win = reqs[win_idx];

  alu #(.DW(DW)) u_alu (
    .sel (win.sel),
    .op1 (win.op1),
    .op2 (win.op2),
    .res (alu_res)
  );

  // Only the slot owner's rsp_ready can free the slot.
  assign slot_drain = out_valid && rsp_ready[out_id];
  assign slot_free  = !out_valid || rsp_ready[out_id];
  assign grant_fire = rst_n && win_any && slot_free;
  assign req_ready  = (rst_n && slot_free) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_res   <= '0;
      rr_ptr    <= '0;
    end else if (grant_fire) begin
      out_valid <= 1'b1;
      out_id    <= win_idx;
      out_res   <= alu_res;
      rr_ptr    <= (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;
    end else if (slot_drain) begin
      out_valid <= 1'b0;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (out_valid) rsp_valid[out_id] = 1'b1;
  end

  assign rsp_res = out_res;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with four requesters: grant order, latency,
// backpressure, pointer wrap, boundary ALU codes and asynchronous reset.
module tb_alu_arbiter;
  localparam logic [3:0] OP_NONE  = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_SLT   = 4'h4;
  localparam logic [3:0] OP_SLTU  = 4'h5;
  localparam logic [3:0] OP_SRA   = 4'h8;
  localparam logic [3:0] OP_OR    = 4'h9;
  localparam logic [3:0] OP_UNDEF = 4'hF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [15:0]  req_sel;
  logic [127:0] req_op1;
  logic [127:0] req_op2;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [31:0]  rsp_res;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.DW(32), .NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    req_sel[4*i +: 4]  = s;
    req_op1[32*i +: 32] = a;
    req_op2[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '1;
    req_sel = '0; req_op1 = '0; req_op2 = '0;
    #3;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if (rsp_res !== 32'h0) begin failures++; $display("FAIL reset_rsp_res got=%h exp=00000000", rsp_res); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    rsp_ready = '1;
    set_req(0, OP_ADD, 32'd5, 32'd7);
    @(negedge clk); req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    @(negedge clk); req_valid = 4'b0000; #1;
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); end
    checks++; if (rsp_res !== 32'd12) begin failures++; $display("FAIL single_rsp_res got=%h exp=0000000c", rsp_res); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_drain got=%b exp=0000", rsp_valid); end
  endtask

  task automatic test_contention();
    logic [3:0]  exp_g, exp_v;
    logic [31:0] exp_r;
    do_reset();
    set_req(0, OP_SUB, 32'd10, 32'd3);
    set_req(1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); req_valid = (k < 4) ? 4'b0011 : 4'b0000; #1;
      exp_g = (k < 4) ? ((k % 2 == 0) ? 4'b0001 : 4'b0010) : 4'b0000;
      checks++; if (req_ready !== exp_g) begin failures++; $display("FAIL contention_grant k=%0d got=%b exp=%b", k, req_ready, exp_g); end
      if (k > 0) begin
        exp_v = (k % 2 == 1) ? 4'b0001 : 4'b0010;
        exp_r = (k % 2 == 1) ? 32'd7 : 32'd1;
        checks++; if (rsp_valid !== exp_v) begin failures++; $display("FAIL contention_rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, exp_v); end
        checks++; if (rsp_res !== exp_r) begin failures++; $display("FAIL contention_rsp_res k=%0d got=%h exp=%h", k, rsp_res, exp_r); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(1, OP_SRA, 32'h8000_0000, 32'd4);
    set_req(0, OP_ADD, 32'd1, 32'd2);
    @(negedge clk); rsp_ready = 4'b1101; req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_first_grant got=%b exp=0010", req_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); req_valid = 4'b0001; #1;
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_stall c=%0d got=%b exp=0000", c, req_ready); end
      checks++; if (rsp_valid !== 4'b0010) begin failures++; $display("FAIL bp_hold_valid c=%0d got=%b exp=0010", c, rsp_valid); end
      checks++; if (rsp_res !== 32'hF800_0000) begin failures++; $display("FAIL bp_hold_res c=%0d got=%h exp=f8000000", c, rsp_res); end
    end
    @(negedge clk); rsp_ready = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_release_grant got=%b exp=0001", req_ready); end
    checks++; if (rsp_valid !== 4'b0010) begin failures++; $display("FAIL bp_release_valid got=%b exp=0010", rsp_valid); end
    @(negedge clk); req_valid = 4'b0000; #1;
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL bp_refill_valid got=%b exp=0001", rsp_valid); end
    checks++; if (rsp_res !== 32'd3) begin failures++; $display("FAIL bp_refill_res got=%h exp=00000003", rsp_res); end
  endtask

  task automatic test_wrap();
    logic [3:0]  pats  [8] = '{4'b1000, 4'b0001, 4'b0010, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
    int          exp_i [8] = '{3, 0, 1, 2, 3, 0, 1, -1};
    logic [3:0]  exp_g;
    logic [31:0] exp_r;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, OP_ADD, 32'(i), 32'd100);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); req_valid = pats[k]; #1;
      exp_g = (exp_i[k] >= 0) ? (4'b0001 << exp_i[k]) : 4'b0000;
      checks++; if (req_ready !== exp_g) begin failures++; $display("FAIL wrap_grant k=%0d got=%b exp=%b", k, req_ready, exp_g); end
      if (k > 0) begin
        exp_g = 4'b0001 << exp_i[k-1];
        exp_r = 32'd100 + 32'(exp_i[k-1]);
        checks++; if (rsp_valid !== exp_g) begin failures++; $display("FAIL wrap_rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, exp_g); end
        checks++; if (rsp_res !== exp_r) begin failures++; $display("FAIL wrap_rsp_res k=%0d got=%h exp=%h", k, rsp_res, exp_r); end
      end
    end
  endtask

  task automatic test_boundary_ops();
    logic [3:0]  sels [6] = '{OP_ADD, OP_SLTU, OP_SLTU, OP_NONE, OP_OR, OP_UNDEF};
    logic [31:0] as   [6] = '{32'd1, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'd5, 32'd5};
    logic [31:0] bs   [6] = '{32'd1, 32'd1, 32'hFFFF_FFFF, 32'd6, 32'd6, 32'd6};
    logic [31:0] exps [6] = '{32'd2, 32'd0, 32'd1, 32'd0, 32'd7, 32'd0};
    logic [3:0]  exp_g;
    rsp_ready = '1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 6) begin
        set_req(0, sels[k], as[k], bs[k]);
        req_valid = 4'b0001;
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      exp_g = (k < 6) ? 4'b0001 : 4'b0000;
      checks++; if (req_ready !== exp_g) begin failures++; $display("FAIL ops_grant k=%0d got=%b exp=%b", k, req_ready, exp_g); end
      if (k > 0) begin
        checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL ops_rsp_valid k=%0d got=%b exp=0001", k, rsp_valid); end
        checks++; if (rsp_res !== exps[k-1]) begin failures++; $display("FAIL ops_rsp_res k=%0d got=%h exp=%h", k, rsp_res, exps[k-1]); end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(2, OP_ADD, 32'd9, 32'd9);
    @(negedge clk); req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL arst_pre_grant2 got=%b exp=0100", req_ready); end
    set_req(0, OP_ADD, 32'd2, 32'd3);
    @(negedge clk); req_valid = 4'b0001; rsp_ready = 4'b1110; #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL arst_pre_grant0 got=%b exp=0001", req_ready); end
    @(negedge clk); req_valid = 4'b0000; #1;
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL arst_held_valid got=%b exp=0001", rsp_valid); end
    checks++; if (rsp_res !== 32'd5) begin failures++; $display("FAIL arst_held_res got=%h exp=00000005", rsp_res); end
    #2; rst_n = 1'b0; #1;
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL arst_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if (rsp_res !== 32'h0) begin failures++; $display("FAIL arst_rsp_res got=%h exp=00000000", rsp_res); end
    @(negedge clk); req_valid = 4'b1111; rsp_ready = 4'b1111; rst_n = 1'b1; #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL arst_first_grant got=%b exp=0001", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL arst_no_stale_rsp got=%b exp=0000", rsp_valid); end
    @(negedge clk); req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_wrap();
    test_boundary_ops();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
